// File: rtl/mem_addr_pkg.sv
// Shared types and constants for the memory-address sequencer and its datapath clients.
package mem_addr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam int SRC_PC     = 0;
    localparam int SRC_ALUOUT = 1;
    localparam int SRC_ALU    = 2;

    localparam int DEF_VEC_BASE = 253;

endpackage

// File: rtl/addr_src_mux.sv
// N:1 combinational address selector; an index with no matching source yields zero.
module addr_src_mux #(
    parameter int ADDR_W  = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
) (
    input  logic [SEL_W-1:0]          sel,
    input  logic [NUM_SRC*ADDR_W-1:0] src_bus,
    output logic [ADDR_W-1:0]         addr
);

    always_comb begin
        addr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                addr = src_bus[i*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/mem_addr_sequencer.sv
// Memory-address source select plus exception-vector fetch sequencer.
// A request accepted in IDLE at edge N yields a one-cycle vec_valid in cycle N+MEM_LAT+1.
module mem_addr_sequencer
    import mem_addr_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int NUM_SRC  = 4,
    parameter int SEL_W    = 2,
    parameter int NUM_VEC  = 3,
    parameter int CODE_W   = 2,
    parameter int VEC_BASE = DEF_VEC_BASE,
    parameter int MEM_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SEL_W-1:0]          src_sel,
    input  logic [NUM_SRC*ADDR_W-1:0] src_bus,
    input  logic                      exc_req,
    input  logic [CODE_W-1:0]         exc_code,
    input  logic [7:0]                mem_rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      busy,
    output logic                      vec_valid,
    output logic [ADDR_W-1:0]         vec_target,
    output logic                      bad_code
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CODE_W:0] NUM_VEC_X = (CODE_W+1)'(NUM_VEC);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                busy_q, busy_d;
    logic                vec_valid_q, vec_valid_d;
    logic [ADDR_W-1:0]   vec_target_q, vec_target_d;
    logic                bad_code_q, bad_code_d;
    logic [ADDR_W-1:0]   mux_addr;

    addr_src_mux #(
        .ADDR_W  (ADDR_W),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_addr_src_mux (
        .sel     (src_sel),
        .src_bus (src_bus),
        .addr    (mux_addr)
    );

    // While fetching, the vector address is pinned to the latched code.
    assign mem_addr   = (state_q == IDLE) ? mux_addr
                                          : ADDR_W'(VEC_BASE) + ADDR_W'(code_q);
    assign busy       = busy_q;
    assign vec_valid  = vec_valid_q;
    assign vec_target = vec_target_q;
    assign bad_code   = bad_code_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        code_d       = code_q;
        busy_d       = busy_q;
        vec_valid_d  = 1'b0;
        vec_target_d = vec_target_q;
        bad_code_d   = bad_code_q;
        case (state_q)
            IDLE: begin
                if (exc_req) begin
                    // Out-of-range codes are flagged and redirected to the last vector.
                    if ({1'b0, exc_code} >= NUM_VEC_X) begin
                        bad_code_d = 1'b1;
                        code_d     = CODE_W'(NUM_VEC - 1);
                    end else begin
                        code_d     = exc_code;
                    end
                    cnt_d   = CNT_W'(MEM_LAT - 1);
                    busy_d  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                vec_target_d = ADDR_W'(mem_rdata);
                vec_valid_d  = 1'b1;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            code_q       <= '0;
            busy_q       <= 1'b0;
            vec_valid_q  <= 1'b0;
            vec_target_q <= '0;
            bad_code_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            code_q       <= code_d;
            busy_q       <= busy_d;
            vec_valid_q  <= vec_valid_d;
            vec_target_q <= vec_target_d;
            bad_code_q   <= bad_code_d;
        end
    end

endmodule

// File: tb/tb_mem_addr_sequencer.sv
// Directed bench: one sequencer with MEM_LAT=1 and one with MEM_LAT=3 on a shared source bus.
module tb_mem_addr_sequencer;
    import mem_addr_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   src_sel;
    logic [127:0] src_bus;

    logic         exc_req1, exc_req3;
    logic [1:0]   exc_code1, exc_code3;
    logic [7:0]   mem_rdata1, mem_rdata3;
    logic [31:0]  mem_addr1, mem_addr3, vt1, vt3;
    logic         busy1, busy3, vv1, vv3, bad1, bad3;

    int n_chk  = 0;
    int n_fail = 0;
    int pulses;

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd253: mem_byte = 8'h3C;
            32'd254: mem_byte = 8'h7C;
            32'd255: mem_byte = 8'hA5;
            default: mem_byte = 8'hEE;
        endcase
    endfunction

    always_comb mem_rdata1 = mem_byte(mem_addr1);
    always_comb mem_rdata3 = mem_byte(mem_addr3);

    mem_addr_sequencer #(.MEM_LAT(1)) u_lat1 (
        .clk        (clk),
        .reset      (reset),
        .src_sel    (src_sel),
        .src_bus    (src_bus),
        .exc_req    (exc_req1),
        .exc_code   (exc_code1),
        .mem_rdata  (mem_rdata1),
        .mem_addr   (mem_addr1),
        .busy       (busy1),
        .vec_valid  (vv1),
        .vec_target (vt1),
        .bad_code   (bad1)
    );

    mem_addr_sequencer #(.MEM_LAT(3)) u_lat3 (
        .clk        (clk),
        .reset      (reset),
        .src_sel    (src_sel),
        .src_bus    (src_bus),
        .exc_req    (exc_req3),
        .exc_code   (exc_code3),
        .mem_rdata  (mem_rdata3),
        .mem_addr   (mem_addr3),
        .busy       (busy3),
        .vec_valid  (vv3),
        .vec_target (vt3),
        .bad_code   (bad3)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [31:0] src_exp [4];
    logic        vv_exp  [9];
    logic        busy_exp[9];

    initial begin
        src_exp  = '{32'h100, 32'h204, 32'h308, 32'h40C};
        vv_exp   = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
        busy_exp = '{1, 1, 0, 1, 1, 0, 1, 1, 0};

        reset     = 1'b1;
        src_sel   = 2'd0;
        src_bus   = {32'h40C, 32'h308, 32'h204, 32'h100};
        exc_req1  = 1'b0;
        exc_code1 = 2'd0;
        exc_req3  = 1'b0;
        exc_code3 = 2'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state and same-cycle passthrough
        chk("rst_busy", busy1, 0);
        chk("rst_vv", vv1, 0);
        chk("rst_vt", vt1, 0);
        chk("rst_bad", bad1, 0);
        chk("rst_busy3", busy3, 0);
        for (int s = SRC_PC; s <= 3; s++) begin
            src_sel = 2'(s);
            #1;
            chk($sformatf("mux_sel%0d", s), mem_addr1, src_exp[s]);
        end
        src_sel = 2'(SRC_PC);

        // Vector fetch, MEM_LAT=1, code 1
        exc_code1 = 2'd1;
        exc_req1  = 1'b1;
        tick();
        exc_req1 = 1'b0;
        chk("f1_busy_a", busy1, 1);
        chk("f1_addr_a", mem_addr1, 254);
        chk("f1_vv_a", vv1, 0);
        tick();
        chk("f1_busy_b", busy1, 1);
        chk("f1_addr_b", mem_addr1, 254);
        chk("f1_vv_b", vv1, 0);
        tick();
        chk("f1_vv", vv1, 1);
        chk("f1_busy_c", busy1, 0);
        chk("f1_vt", vt1, 32'h7C);
        chk("f1_addr_idle", mem_addr1, 32'h100);
        tick();
        chk("f1_vv_off", vv1, 0);
        chk("f1_vt_hold", vt1, 32'h7C);

        // Latency sweep, MEM_LAT=3, code 2
        exc_code3 = 2'd2;
        exc_req3  = 1'b1;
        tick();
        exc_req3 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("l3_busy%0d", k), busy3, 1);
            chk($sformatf("l3_addr%0d", k), mem_addr3, 255);
            chk($sformatf("l3_vv%0d", k), vv3, 0);
            tick();
        end
        chk("l3_vv", vv3, 1);
        chk("l3_busy_off", busy3, 0);
        chk("l3_vt", vt3, 32'hA5);

        // Inputs changing mid-fetch are ignored
        exc_code1 = 2'd0;
        exc_req1  = 1'b1;
        tick();
        exc_req1  = 1'b0;
        exc_code1 = 2'd2;
        src_sel   = 2'(SRC_ALUOUT);
        #1;
        chk("chg_addr_a", mem_addr1, 253);
        tick();
        chk("chg_addr_b", mem_addr1, 253);
        tick();
        chk("chg_vv", vv1, 1);
        chk("chg_vt", vt1, 32'h3C);
        chk("chg_addr_idle", mem_addr1, 32'h204);

        // Out-of-range code: sticky flag, last vector used
        exc_code1 = 2'd3;
        exc_req1  = 1'b1;
        tick();
        exc_req1 = 1'b0;
        chk("bad_flag", bad1, 1);
        chk("bad_addr", mem_addr1, 255);
        tick();
        tick();
        chk("bad_vv", vv1, 1);
        chk("bad_vt", vt1, 32'hA5);
        exc_code1 = 2'd1;
        exc_req1  = 1'b1;
        tick();
        exc_req1 = 1'b0;
        tick();
        tick();
        chk("good_vt", vt1, 32'h7C);
        chk("bad_sticky", bad1, 1);

        // Reset in WAIT aborts the fetch; held request then refetches once per IDLE entry
        exc_code1 = 2'd0;
        exc_req1  = 1'b1;
        tick();
        chk("mid_busy", busy1, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", busy1, 0);
        chk("abort_vv", vv1, 0);
        chk("abort_vt", vt1, 0);
        chk("abort_bad", bad1, 0);
        chk("abort_addr", mem_addr1, 32'h204);
        pulses = 0;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk($sformatf("held_vv%0d", k), vv1, vv_exp[k]);
            chk($sformatf("held_busy%0d", k), busy1, busy_exp[k]);
            if (vv1 === 1'b1) pulses++;
        end
        exc_req1 = 1'b0;
        chk("held_pulses", pulses, 3);
        chk("held_vt", vt1, 32'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
